// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts one word per valid/ready handshake and
// shifts it out one bit per clock with a bit-valid qualifier and end-of-word marker.
module piso_serializer #(
  parameter int DATA_WIDTH = 10,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] par_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  x_o,
  output logic                  x_valid_o,
  output logic                  last_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic                    x_q;
  logic                    x_valid_q;
  logic                    last_q;
  logic                    accept;

  // Bit that goes on the wire first for a word held in the shift register.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  assign ready_o   = (state_q == IDLE) | last_q;
  assign accept    = valid_i & ready_o;
  assign x_o       = x_q;
  assign x_valid_o = x_valid_q;
  assign last_o    = last_q;

  always_comb begin
    shreg_d = advance(shreg_q);
    cnt_d   = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SHIFT;
            shreg_q   <= par_i;
            x_q       <= head_bit(par_i);
            x_valid_q <= 1'b1;
            cnt_q     <= '0;
            last_q    <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            // Final bit on the wire: either chain the next word or fall back to idle.
            if (accept) begin
              shreg_q   <= par_i;
              x_q       <= head_bit(par_i);
              x_valid_q <= 1'b1;
              cnt_q     <= '0;
              last_q    <= 1'b0;
            end else begin
              state_q   <= IDLE;
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
              cnt_q     <= '0;
              last_q    <= 1'b0;
            end
          end else begin
            shreg_q <= shreg_d;
            x_q     <= head_bit(shreg_d);
            cnt_q   <= cnt_d;
            last_q  <= (cnt_d == CNT_LAST);
          end
        end
        default: begin
          state_q   <= IDLE;
          x_q       <= 1'b0;
          x_valid_q <= 1'b0;
          cnt_q     <= '0;
          last_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
